// File: rtl/stolic_link_if.sv
// Word channel bundle between a sending tile, the link buffer and the
// receiving tile. The link itself connects through the slave modport.
interface stolic_link_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_tgl;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_tgl;
    logic          rd_ack_tgl;
    logic [AW:0]   level;
    logic          ovf;
    logic          ovf_clr;
    logic [7:0]    drop_cnt;

    // Tile side: offers words, acknowledges them and reads status
    modport master (
        output wr_tgl, wr_data, rd_ack_tgl, ovf_clr,
        input  rd_data, rd_tgl, level, ovf, drop_cnt
    );

    // Link side
    modport slave (
        input  wr_tgl, wr_data, rd_ack_tgl, ovf_clr,
        output rd_data, rd_tgl, level, ovf, drop_cnt
    );
endinterface

// File: rtl/stolic_link.sv
// Toggle-handshake word FIFO between two adjacent systolic tiles.
// A sender toggle edge offers one word; a word is presented on rd_data with a
// rd_tgl flip and is considered consumed once rd_ack_tgl matches rd_tgl.
module stolic_link #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic           wb_clk,
    input  logic           wb_rst,
    stolic_link_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem [DEPTH];

    logic          wr_tgl_q_reg;
    logic          rd_tgl_reg;
    logic [DW-1:0] rd_data_reg;
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic          ovf_reg;
    logic [7:0]    drop_cnt_reg;

    logic wr_ev;
    logic out_busy;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a word when a pop frees a slot on the same edge
    always_comb begin
        wr_ev    = bus.wr_tgl ^ wr_tgl_q_reg;
        out_busy = rd_tgl_reg != bus.rd_ack_tgl;
        full     = level_reg == LVL_FULL;
        pop      = !out_busy && (level_reg != '0);
        push     = wr_ev && (!full || pop);
        drop     = wr_ev && full && !pop;
    end

    // Occupancy after this cycle's push and pop
    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LVL_ONE;
        end else if (pop && !push) begin
            level_next = level_reg - LVL_ONE;
        end
    end

    // Storage array, no reset so it can map onto RAM; a same-address read
    // during a full-and-pop cycle returns the old word, as required
    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem[wptr_reg] <= bus.wr_data;
        end
    end

    // Handshake, pointer and occupancy state; reset resynchronises both toggles
    // to the tiles' current levels so nothing appears pending on release
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_tgl_q_reg <= bus.wr_tgl;
            rd_tgl_reg   <= bus.rd_ack_tgl;
            rd_data_reg  <= '0;
            level_reg    <= '0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
        end else begin
            wr_tgl_q_reg <= bus.wr_tgl;
            level_reg    <= level_next;
            if (push) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_data_reg <= mem[rptr_reg];
                rptr_reg    <= rptr_reg + PTR_ONE;
                rd_tgl_reg  <= ~rd_tgl_reg;
            end
        end
    end

    // Drop status; a drop coinciding with a clear leaves exactly one drop recorded
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (bus.ovf_clr) begin
            ovf_reg      <= drop;
            drop_cnt_reg <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_tgl   = rd_tgl_reg;
    assign bus.level    = level_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_stolic_link.sv
// Bench for stolic_link: queue-based reference model, scoreboard of expected
// deliveries, and a negedge monitor comparing every cycle's status.
module tb_stolic_link;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic wb_clk = 1'b0;
    logic wb_rst;

    stolic_link_if #(.DEPTH(DEPTH), .DW(DW)) lnk ();

    stolic_link #(.DEPTH(DEPTH), .DW(DW)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (lnk.slave)
    );

    always #5 wb_clk = ~wb_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] held[$];     // words waiting in the FIFO
    logic [DW-1:0] exp_q[$];    // scoreboard: words expected to appear on rd_data
    logic          m_wq;
    logic          m_rdt;
    logic [DW-1:0] m_rd;
    bit            m_ovf;
    int            m_drop;

    int   n_deliv   = 0;
    int   max_level = 0;
    logic last_tgl;

    bit auto_ack  = 1'b0;
    int ack_delay = 0;
    int ack_wait  = 0;

    function automatic void check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Reference model: a word leaves the queue whenever nothing is outstanding,
    // an offered word enters if there is room after that, otherwise it is lost
    always @(posedge wb_clk) begin
        bit ev;
        bit dropped;
        if (wb_rst) begin
            m_wq  = lnk.wr_tgl;
            m_rdt = lnk.rd_ack_tgl;
            m_rd  = '0;
            m_ovf = 1'b0;
            m_drop = 0;
            held.delete();
            exp_q.delete();
        end else begin
            ev   = (lnk.wr_tgl != m_wq);
            m_wq = lnk.wr_tgl;
            if (m_rdt == lnk.rd_ack_tgl && held.size() > 0) begin
                m_rd  = held.pop_front();
                m_rdt = ~m_rdt;
                exp_q.push_back(m_rd);
            end
            dropped = 1'b0;
            if (ev) begin
                if (held.size() < DEPTH) held.push_back(lnk.wr_data);
                else dropped = 1'b1;
            end
            if (lnk.ovf_clr) begin
                m_ovf  = dropped;
                m_drop = dropped ? 1 : 0;
            end else if (dropped) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    end

    // Monitor: status every cycle, scoreboard pop on every new word
    always @(negedge wb_clk) begin
        logic [DW-1:0] w;
        if (wb_rst) begin
            last_tgl = lnk.rd_tgl;
        end else begin
            check("level", lnk.level, held.size());
            check("ovf", lnk.ovf, m_ovf);
            check("drop_cnt", lnk.drop_cnt, m_drop);
            check("rd_tgl", lnk.rd_tgl, m_rdt);
            check("rd_data_hold", lnk.rd_data, m_rd);
            if (int'(lnk.level) > max_level) max_level = int'(lnk.level);
            if (lnk.rd_tgl != last_tgl) begin
                last_tgl = lnk.rd_tgl;
                if (exp_q.size() == 0) begin
                    check("spurious_load", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    n_deliv++;
                    $display("[TB] word %0d delivered 0x%08h (expected 0x%08h)", n_deliv, lnk.rd_data, w);
                    check("deliver", lnk.rd_data, w);
                end
            end
        end
    end

    // One clock step; inputs change 2 time units after the edge
    task automatic tick();
        @(posedge wb_clk);
        #2;
        if (auto_ack && lnk.rd_tgl != lnk.rd_ack_tgl) begin
            if (ack_wait >= ack_delay) begin
                lnk.rd_ack_tgl = lnk.rd_tgl;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [DW-1:0] d);
        lnk.wr_data = d;
        lnk.wr_tgl  = ~lnk.wr_tgl;
        tick();
    endtask

    initial begin
        int n0;
        int sent;

        wb_rst         = 1'b1;
        lnk.wr_tgl     = 1'b1;
        lnk.rd_ack_tgl = 1'b1;
        lnk.wr_data    = '0;
        lnk.ovf_clr    = 1'b0;

        // Reset with both tile toggles high: must leave reset idle
        ticks(3);
        wb_rst = 1'b0;
        ticks(10);
        check("reset_rd_tgl", lnk.rd_tgl, 1);
        check("reset_level", lnk.level, 0);
        check("reset_rd_data", lnk.rd_data, 0);
        check("reset_ovf", lnk.ovf, 0);

        // Single word latency on an idle link
        send(32'hDEADBEEF);
        check("lat_level_k", lnk.level, 1);
        tick();
        check("lat_rd_data", lnk.rd_data, 32'hDEADBEEF);
        check("lat_rd_tgl", lnk.rd_tgl, 0);
        check("lat_level_k1", lnk.level, 0);
        lnk.rd_ack_tgl = lnk.rd_tgl;
        ticks(3);

        // Receiver silent: six words into a four-deep FIFO
        for (int i = 1; i <= 6; i++) send(i);
        check("full_rd_data", lnk.rd_data, 1);
        check("full_level", lnk.level, 4);
        check("full_ovf", lnk.ovf, 1);
        check("full_drop_cnt", lnk.drop_cnt, 1);

        // Ack and write on the same edge while full
        lnk.rd_ack_tgl = lnk.rd_tgl;
        send(7);
        check("ackwr_level", lnk.level, 4);
        check("ackwr_rd_data", lnk.rd_data, 2);
        check("ackwr_drop_cnt", lnk.drop_cnt, 1);
        auto_ack  = 1'b1;
        ack_delay = 0;
        ticks(20);
        check("drain_last", lnk.rd_data, 7);
        check("drain_level", lnk.level, 0);

        // Plain clear
        lnk.ovf_clr = 1'b1;
        tick();
        lnk.ovf_clr = 1'b0;
        check("clr_ovf", lnk.ovf, 0);
        check("clr_drop_cnt", lnk.drop_cnt, 0);

        // Saturation of the drop counter, then clear colliding with a drop
        auto_ack = 1'b0;
        for (int i = 0; i < 305; i++) send($urandom);
        check("sat_drop_cnt", lnk.drop_cnt, 255);
        check("sat_ovf", lnk.ovf, 1);
        lnk.ovf_clr = 1'b1;
        send($urandom);
        lnk.ovf_clr = 1'b0;
        check("clrset_ovf", lnk.ovf, 1);
        check("clrset_drop_cnt", lnk.drop_cnt, 1);
        lnk.ovf_clr = 1'b1;
        tick();
        lnk.ovf_clr = 1'b0;

        // Stream of 20 words, receiver acking three cycles after each word
        auto_ack  = 1'b1;
        ack_delay = 3;
        ack_wait  = 0;
        ticks(40);
        n0 = n_deliv;
        max_level = 0;
        sent = 0;
        for (int c = 0; c < 600 && sent < 20; c++) begin
            if (held.size() < DEPTH) begin
                send($urandom);
                sent++;
            end else begin
                tick();
            end
        end
        ticks(80);
        check("stream_sent", sent, 20);
        check("stream_delivered", n_deliv - n0, 20);
        check("stream_drops", lnk.drop_cnt, 0);
        check("stream_max_level", (max_level <= DEPTH) ? 1 : 0, 1);

        // Mid-operation reset with both toggles moved during reset
        auto_ack = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom);
        wb_rst         = 1'b1;
        lnk.wr_tgl     = ~lnk.wr_tgl;
        lnk.rd_ack_tgl = ~lnk.rd_ack_tgl;
        ticks(3);
        wb_rst = 1'b0;
        ticks(5);
        check("mrst_level", lnk.level, 0);
        check("mrst_rd_data", lnk.rd_data, 0);
        check("mrst_ovf", lnk.ovf, 0);
        check("mrst_rd_tgl", lnk.rd_tgl, lnk.rd_ack_tgl);

        // Random traffic against the model
        auto_ack = 1'b1;
        ack_wait = 0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) ack_delay = $urandom_range(0, 4);
            lnk.ovf_clr = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 1) == 1) send($urandom);
            else tick();
        end
        lnk.ovf_clr = 1'b0;
        ack_delay = 0;
        ticks(40);
        check("final_level", lnk.level, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stolic_link.md
Name: stolic_link

Overview:
Point-to-point word channel between two adjacent tiles of the systolic servant array. It is the stage directly downstream of a tile's directional GPIO output bus (e.g. north) and directly upstream of the neighbour's matching directional GPIO input bus (e.g. south). Both sides use a toggle handshake, because tile GPIO strobes are software-written level bits, not single-cycle pulses. The block buffers up to DEPTH words so the sending tile does not stall on a slow receiver, and reports overflow/drop status.

Parameters:
DEPTH, 4, FIFO depth in words; power of 2, >= 2
AW, $clog2(DEPTH), pointer width; derived, not overridden
DW, 32, word width; matches tile GPIO bus width

Ports:
wb_clk  input  1  clock, shared with the tiles
wb_rst  input  1  synchronous active-high reset
wr_tgl  input  1  sender strobe; each transition (0->1 or 1->0) offers one word
wr_data  input  DW  sender word; sampled in the cycle the wr_tgl transition is detected
rd_data  output  DW  word presented to the receiver tile
rd_tgl  output  1  toggles once each time a new word is loaded onto rd_data
rd_ack_tgl  input  1  receiver ack; word consumed when rd_ack_tgl equals rd_tgl
level  output  AW+1  words held in the FIFO, excluding the word on rd_data
ovf  output  1  sticky flag; set when a word is dropped
ovf_clr  input  1  clears ovf and drop_cnt
drop_cnt  output  8  count of dropped words, saturates at 255

Behaviour:
- Clock and reset: all state updates on the rising edge of wb_clk. wb_rst is synchronous and active-high.
- Reset values: rd_data=0, level=0, ovf=0, drop_cnt=0, rd/wr pointers=0.
- While wb_rst is high: wr_tgl_q <= wr_tgl and rd_tgl <= rd_ack_tgl. The block leaves reset idle, with no spurious word and no outstanding word, whatever level the tile GPIOs hold.
- Write-edge detection: wr_ev = wr_tgl ^ wr_tgl_q. wr_tgl_q <= wr_tgl every cycle.
- Push: when wr_ev=1 and the FIFO is not full, write wr_data at wptr and increment wptr, wrapping modulo DEPTH.
- Outstanding state: out_busy = (rd_tgl != rd_ack_tgl).
- Pop/load: when out_busy=0 and level>0, then on that edge:
  - rd_data <= mem[rptr];
  - rptr increments, wrapping modulo DEPTH;
  - rd_tgl inverts.
  rd_data stays stable while out_busy=1.
- Latency: with an empty, idle link, a wr_tgl transition sampled at edge k gives level=1 after k. At edge k+1: rd_data = word, rd_tgl toggles, level=0.
- Level update: level = level + push - pop. Never exceeds DEPTH and never underflows.
- Full with a write: when level==DEPTH and wr_ev=1:
  - if a pop occurs the same cycle, the push is accepted and level is unchanged;
  - otherwise the word is dropped, ovf <= 1, and drop_cnt increments, saturating at 255.
- Empty with a pop condition: nothing happens; rd_data and rd_tgl hold.
- ovf_clr: clears ovf and drop_cnt. If a drop occurs in the same cycle, set wins: ovf=1 and drop_cnt=1.
- Ack handling: rd_ack_tgl is treated as a level compare only. Extra ack toggles from the receiver, when rd_ack_tgl already equals rd_tgl, make out_busy=1 falsely. Receiver firmware must echo rd_tgl exactly; the block does not detect this error.
- Throughput: at most one push and one pop per cycle. A new word can load on the edge after the ack is observed.
- Mid-operation reset: FIFO contents are discarded and all status is cleared. Toggle state is resynchronised as described above.

Test Plan:
- Reset with wr_tgl=1 and rd_ack_tgl=1 -> after release: rd_tgl=1, level=0, rd_data=0, no load for 10 cycles.
- Idle link; toggle wr_tgl with wr_data=0xDEADBEEF -> one cycle later level=1; next cycle rd_data=0xDEADBEEF, rd_tgl flips, level=0.
- DEPTH=4, receiver never acks; 6 write toggles with data 1..6 -> rd_data=1, level=4 (words 2..5), word 6 dropped, ovf=1, drop_cnt=1.
- Same state; ack and write toggle in the same cycle -> word accepted, level stays 4, ovf unchanged. Then the ack sequence delivers 2,3,4,5,7 in order.
- 300 dropped words -> drop_cnt=255. Pulse ovf_clr together with a drop -> ovf=1, drop_cnt=1.
- Back-to-back stream of 20 words, with the receiver acking 3 cycles after each rd_tgl change -> all 20 words delivered in order, no drops, level never exceeds 4.
